// File: rtl/matmul_pkg.sv
// Shared widths, FSM state codes and small index helpers for the matmul result serializer.
package matmul_pkg;

    localparam int unsigned OUT_W   = 10;
    localparam int unsigned MAX_DIM = 3;
    localparam int unsigned NUM_EL  = MAX_DIM * MAX_DIM;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned ST_W    = 2;

    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_SEND = 2'd1;
    localparam logic [ST_W-1:0] ST_CSUM = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE = 2'd3;

    function automatic logic dim_legal(input logic [IDX_W-1:0] d);
        return (d != 2'd0) && (32'(d) <= MAX_DIM);
    endfunction

    function automatic logic is_last(input logic [IDX_W-1:0] row, input logic [IDX_W-1:0] col,
                                     input logic [IDX_W-1:0] rows, input logic [IDX_W-1:0] cols);
        return (row == rows - 2'd1) && (col == cols - 2'd1);
    endfunction

    function automatic logic [3:0] el_index(input logic [IDX_W-1:0] row, input logic [IDX_W-1:0] col);
        return 4'(row) * 4'(MAX_DIM) + 4'(col);
    endfunction

endpackage

// File: rtl/matmul_result_serializer_rc_index_counter.sv
// Row-major row/col walker: clears to (0,0), steps on each accepted word, flags the final element.
module rc_index_counter
    import matmul_pkg::*;
(
    input  logic             clk,
    input  logic             clear_n,
    input  logic             clr,
    input  logic             en,
    input  logic [IDX_W-1:0] rows,
    input  logic [IDX_W-1:0] cols,
    output logic [IDX_W-1:0] row_nxt_c,
    output logic [IDX_W-1:0] col_nxt_c,
    output logic             last_c
);

    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = '0;
            col_d = '0;
        end else if (en) begin
            if (col_q == cols - 2'd1) begin
                col_d = '0;
                row_d = row_q + 2'd1;
            end else begin
                col_d = col_q + 2'd1;
            end
        end
    end

    assign row_nxt_c = row_d;
    assign col_nxt_c = col_d;
    assign last_c    = is_last(row_q, col_q, rows, cols);

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

endmodule

// File: rtl/matmul_result_serializer.sv
// Snapshots the 3x3 result array on start and streams the rows x cols sub-matrix over valid/ready.
// Optional checksum trailer word when SER_CHECKSUM_EN is defined.
module matmul_result_serializer
    import matmul_pkg::*;
(
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic                    start,
    input  logic [IDX_W-1:0]        rows,
    input  logic [IDX_W-1:0]        cols,
    input  logic [NUM_EL*OUT_W-1:0] res_flat,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic [IDX_W-1:0]        out_row,
    output logic [IDX_W-1:0]        out_col,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

`ifdef SER_CHECKSUM_EN
    localparam logic CSUM_EN = 1'b1;
`else
    localparam logic CSUM_EN = 1'b0;
`endif

    logic [ST_W-1:0]         state_q, state_d;
    logic [NUM_EL*OUT_W-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]        rows_q, rows_d, cols_q, cols_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic [IDX_W-1:0]        out_row_q, out_row_d, out_col_q, out_col_d;
    logic                    out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef SER_CHECKSUM_EN
    logic [OUT_W-1:0]        csum_q, csum_d;
`endif

    logic             start_ok, xfer, cnt_clr, cnt_en, last_c, load_out, finish;
    logic [IDX_W-1:0] row_nxt_c, col_nxt_c;

    function automatic logic [OUT_W-1:0] word_at(input logic [NUM_EL*OUT_W-1:0] v, input logic [3:0] idx);
        logic [OUT_W-1:0] w;
        w = '0;
        for (int i = 0; i < int'(NUM_EL); i++) begin
            if (idx == 4'(i)) w = v[i*OUT_W +: OUT_W];
        end
        return w;
    endfunction

    assign start_ok = start && dim_legal(rows) && dim_legal(cols);
    assign xfer     = out_valid_q && out_ready;
    assign cnt_clr  = (state_q == ST_IDLE) && start_ok;
    assign cnt_en   = (state_q == ST_SEND) && xfer && !last_c;

    rc_index_counter u_cnt (
        .clk       (clk),
        .clear_n   (clear_n),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .rows      (rows_q),
        .cols      (cols_q),
        .row_nxt_c (row_nxt_c),
        .col_nxt_c (col_nxt_c),
        .last_c    (last_c)
    );

    // Next state and next registered outputs; the word register is loaded from the counter's next index.
    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        out_data_d  = out_data_q;
        out_row_d   = out_row_q;
        out_col_d   = out_col_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        load_out    = 1'b0;
        finish      = 1'b0;
`ifdef SER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (start_ok) begin
                        buf_d       = res_flat;
                        rows_d      = rows;
                        cols_d      = cols;
                        state_d     = ST_SEND;
                        out_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        load_out    = 1'b1;
`ifdef SER_CHECKSUM_EN
                        csum_d      = '0;
`endif
                    end else begin
                        err_d  = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            ST_SEND: begin
                if (xfer) begin
`ifdef SER_CHECKSUM_EN
                    csum_d = csum_q + out_data_q;
`endif
                    if (last_c) begin
`ifdef SER_CHECKSUM_EN
                        state_d    = ST_CSUM;
                        out_data_d = csum_q + out_data_q;
                        out_row_d  = 2'd3;
                        out_col_d  = 2'd3;
                        out_last_d = 1'b1;
`else
                        finish = 1'b1;
`endif
                    end else begin
                        load_out = 1'b1;
                    end
                end
            end
`ifdef SER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) finish = 1'b1;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_row_d   = '0;
            out_col_d   = '0;
            out_last_d  = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
        end
        if (load_out) begin
            out_data_d = word_at(buf_d, el_index(row_nxt_c, col_nxt_c));
            out_row_d  = row_nxt_c;
            out_col_d  = col_nxt_c;
            out_last_d = !CSUM_EN && is_last(row_nxt_c, col_nxt_c, rows_d, cols_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q     <= ST_IDLE;
            buf_q       <= '0;
            rows_q      <= '0;
            cols_q      <= '0;
            out_data_q  <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef SER_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            out_data_q  <= out_data_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef SER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/matmul_result_serializer.md
Name: matmul_result_serializer

Overview:
- Reader end of the matmul result interface.
- Snapshots the 3x3 parallel result array (o11..o33) on a start pulse.
- Streams the valid rows x cols sub-matrix out one word per transfer, row-major, over a valid/ready handshake.
- Sits between matmul and the downstream consumer (UART/host bridge); replaces reading internal o-signals.

Parameters:
- OUT_W, 10, result word width; 4b x 4b products summed over 3 terms fit in 10 bits.
- MAX_DIM, 3, maximum rows/cols; fixed by the 3x3 MAC array.

Ports:
- clk  in  1  rising-edge clock
- clear_n  in  1  synchronous active-low reset
- start  in  1  one-cycle request to snapshot and send
- rows  in  2  result rows (= row_w of the multiply), legal 1..3
- cols  in  2  result cols (= col_x of the multiply), legal 1..3
- res_flat  in  9*OUT_W  o11 at [OUT_W-1:0], o12 next, ... o33 at top; row-major
- out_data  out  OUT_W  current word
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_last  out  1  final word of the frame
- out_row  out  2  row index of out_data (0-based)
- out_col  out  2  col index of out_data (0-based)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last accepted word
- err  out  1  sticky; set on illegal dimensions

Behaviour:
- Reset: all outputs 0, state IDLE, snapshot buffer cleared, err cleared. Reset mid-frame aborts the frame with no done pulse.
- States: IDLE, SEND, [CSUM], DONE.
- IDLE:
  - start=1 with rows and cols both in 1..3: latch res_flat, rows and cols into the buffer; row/col counters to 0; go to SEND.
  - start=1 with rows=0 or cols=0: set err, pulse done next cycle, emit nothing, stay IDLE.
- SEND:
  - Latency: start sampled at edge N gives out_valid=1 with element (0,0) from edge N+1.
  - out_data = buf[row*3+col]; busy=1.
  - Transfer occurs when out_valid && out_ready.
  - out_data/out_row/out_col/out_last hold stable while out_valid && !out_ready.
  - On transfer: col++; on col==cols-1, wrap col to 0 and row++.
  - out_last=1 exactly when row==rows-1 && col==cols-1.
  - Transfer with out_last set goes to DONE (or CSUM if enabled).
  - Back-to-back transfers are allowed every cycle; a rows x cols frame takes rows*cols cycles with out_ready held high.
- DONE: out_valid=0, done=1 for one cycle, busy=0, then IDLE.
- start while busy is ignored; no re-latch, counters untouched.
- res_flat changes after the snapshot do not affect the frame in progress.
- start on the same cycle as DONE is ignored; it is accepted the following cycle in IDLE.
- err clears only on reset.

Optional Feature:
- Macro: SER_CHECKSUM_EN.
- Defined:
  - After the last data word, state CSUM emits one trailer word = sum of all sent words mod 2^OUT_W, with the same handshake rules.
  - out_last moves to the trailer word; out_row=3, out_col=3 on the trailer.
  - Frame length is rows*cols+1.
- Undefined: CSUM state and accumulator absent; behaviour as above.

Decomposition:
- Shared package matmul_pkg: OUT_W, MAX_DIM, state enum (ST_IDLE, ST_SEND, ST_CSUM, ST_DONE), dimension-legal check function.
- One natural sub-module, rc_index_counter: row/col counter with wrap at cols-1, last flag, and enable on transfer.

Test Plan:
- 3x3, res_flat = 1..9 row-major, out_ready=1 -> words 1..9 on 9 consecutive cycles; out_last on 9; done pulse 1 cycle later.
- 2x2, o11=34 o12=40 o21=130 o22=180, out_ready toggled 1,0,0,1,1 -> words 34,40,130,180 in order; data held stable during stalls; (row,col) sequence (0,0),(0,1),(1,0),(1,1).
- 3x2 with rows=3 cols=2 and res_flat changed to all 0x3FF one cycle after start -> original 6 words sent (o11,o12,o21,o22,o31,o32), no 0x3FF seen.
- start with rows=0 -> no out_valid; err=1; done pulse; a second start mid-frame of a 1x1 frame is ignored.
- clear_n low for one cycle during word 2 of a 3x3 frame -> all outputs 0 next cycle, no done; a new start then sends a full frame.
- SER_CHECKSUM_EN, 1x1 frame with o11=20 -> words 20 then trailer 20; out_last only on the trailer.
